// File: rtl/rsl_scheduler.sv
// rsl_scheduler: round-robin arbiter in front of one shared bit-serial right shifter
module rsl_scheduler #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [CNT_W-1:0] sh0,
  input  logic [CNT_W-1:0] sh1,
  input  logic             ar0,
  input  logic             ar1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] out
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic last, win, ar, id, sel_ar;
  logic [WIDTH-1:0] work, sel_a, shifted;
  logic [CNT_W-1:0] cnt, sel_sh;
  always_comb begin
    win = (req0 & req1) ? ~last : req1;
    sel_a = win ? a1 : a0;
    sel_sh = win ? sh1 : sh0;
    sel_ar = win ? ar1 : ar0;
    shifted = {ar & work[WIDTH-1], work[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      out <= '0;
      done <= 1'b0;
      done_id <= 1'b0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      busy <= 1'b0;
      work <= '0;
      cnt <= '0;
      ar <= 1'b0;
      id <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      if (state == IDLE) begin
        if (req0 | req1) begin
          gnt0 <= ~win;
          gnt1 <= win;
          last <= win;
          id <= win;
          work <= sel_a;
          cnt <= sel_sh;
          ar <= sel_ar;
          if (sel_sh == '0) begin
            out <= sel_a;
            done <= 1'b1;
            done_id <= win;
          end else begin
            state <= SHIFT;
            busy <= 1'b1;
          end
        end
      end else begin
        work <= shifted;
        cnt <= cnt - 1'b1;
        if (cnt == 1) begin
          out <= shifted;
          done <= 1'b1;
          done_id <= id;
          busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: doc/rsl_scheduler.md
# rsl_scheduler

Shares one multi-step right-shift datapath between two requesters in the T_Rot arithmetic path. Each request carries a 32-bit operand, a shift count and a logical/arithmetic flag. The block arbitrates round-robin, then shifts the latched operand one bit per clock for the requested count, mirroring the single-step RSL operation. It returns the result with a one-cycle done pulse tagged by requester ID.

## Interface
- WIDTH, 32, operand/result width.
- CNT_W, 5, shift-count width; max count 2^CNT_W-1 = 31.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  level request from requester 0/1.
- a0 / a1  in  WIDTH  operand; held stable while reqN is high.
- sh0 / sh1  in  CNT_W  shift count N.
- ar0 / ar1  in  1  1 = arithmetic shift (sign fill), 0 = logical shift (zero fill).
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted and operands latched.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse: out valid.
- done_id  out  1  requester served by the current done.
- out  out  WIDTH  result; holds until the next done.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE, no request: all pulses low.
- IDLE, any reqN high at an edge, called the accept edge E0:
  - Select a requester. If only one requests, it wins. If both request, the one not last served wins.
  - Latch operand, count and flag into the working register. Register gntN = 1 for one cycle. Update last_served.
  - If N = 0: out <= operand, done <= 1, done_id <= winner; stay in IDLE.
  - If N ≥ 1: state <= SHIFT, busy <= 1.
- SHIFT, at each edge:
  - work <= {fill, work[WIDTH-1:1]}; fill = work[WIDTH-1] if arithmetic, else 0.
  - Decrement the remaining count.
  - On the edge performing the Nth shift: out <= shifted value, done <= 1, done_id <= winner, busy <= 0, state <= IDLE.
- Requests are not sampled in SHIFT. Pending requests wait, holding req and operands stable.
- Requester deasserts reqN in the cycle gntN is high. A req still high at the next IDLE edge is a new request.
- Result: logical = a >> N; arithmetic = a >>> N (signed). N = 31 arithmetic on a negative operand gives all ones.
- Reset (any state, including mid-SHIFT):
  - Outputs: out = 0, done = 0, done_id = 0, gnt0 = gnt1 = 0, busy = 0.
  - Internal: state = IDLE, last_served = 1, so req0 wins the first conflict.
  - An in-flight operation is discarded with no done. reqN high during rst is ignored; sampling starts at the first edge with rst low.

## Timing
- All outputs registered; no combinational input-to-output path.
- gntN high the cycle after E0.
- N ≥ 1: busy high from the cycle after E0 through the cycle after E(N-1). done and out valid the cycle after EN, i.e. N cycles after gnt.
- N = 0: done and gnt high in the same cycle (cycle after E0).
- The edge ending the done cycle is an IDLE edge, so a new accept can occur there. Throughput: one operation per N+1 cycles; one per cycle for N = 0.
- Both requests at the same edge: exactly one gnt; the loser is served at the first IDLE edge after its competitor's done.

## Test plan
- Logical shift: req0, a0 = 0x80000000, sh0 = 4, ar0 = 0.
  - gnt0 one cycle; busy 4 cycles.
  - done 4 cycles after gnt0, out = 0x08000000, done_id = 0.
- Arithmetic shift: req1, a1 = 0x80000000, sh1 = 31, ar1 = 1.
  - done 31 cycles after gnt1, out = 0xFFFFFFFF, done_id = 1.
  - Repeat with ar1 = 0: out = 0x00000001.
- Contention, after reset: req0 and req1 both high, sh = 2 each, held until granted.
  - gnt0 first; gnt1 accepted at the edge ending done(id 0); done(id 1) follows 2 cycles after gnt1.
  - Both requesting again afterwards: gnt0 wins (last_served = 1).
- Zero count: req0, a0 = 0x12345678, sh0 = 0.
  - gnt0 and done in the same cycle; out = 0x12345678; busy stays 0.
- Reset mid-operation: req1, sh1 = 10, rst high at the third SHIFT edge.
  - No done; out = 0, busy = 0.
  - Then req1, a1 = 0xF0, sh1 = 4, ar1 = 0: out = 0x0000000F.
- Ignore while busy: req1 held high during req0's 6-cycle shift.
  - No gnt1 until done(id 0); gnt1 in the cycle after done.
